uart_rx_deserializer: RTL and testbench

- Standalone UART receiver: recovers bytes from an asynchronous serial line using a programmable clocks-per-bit divisor with mid-bit sampling.
- Counterpart to the bit-serial stimulus driven into the UART's rx pin; decodes the UART tx line back into bytes for SoC loopback and self-check paths.
- Presents decoded bytes through a one-entry holding register with a valid/ready handshake, drives rts_n flow control, and reports framing, parity and overrun errors as single-cycle pulses.

---
 rtl/uart_rx_deserializer.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receiver: recovers 8-bit bytes from an asynchronous serial line.
// A programmable clocks-per-bit divisor drives mid-bit sampling. Bytes are
// presented through a one-entry holding register with a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            receiver enable; low aborts a frame and holds the FSM idle
//   divisor           clocks per bit, values below 4 are treated as 4
//   parity_en         a parity bit follows the data bits
//   parity_odd        1 = odd parity, 0 = even
//   rx                asynchronous serial input, idles high
//   out_data          received byte (LSB first on the line)
//   out_valid         holding register full
//   out_ready         consumer accepts the byte when out_valid & out_ready
//   rts_n             active-low ready-to-receive
//   frame_err         1-cycle pulse: stop bit sampled low
//   parity_err        1-cycle pulse: parity mismatch
//   overrun           1-cycle pulse: byte completed while holding register full
module uart_rx_deserializer #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] divisor,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             rx,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             rts_n,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_s_d;
    logic [DIV_W-1:0]       r_div_q;
    logic [DIV_W-1:0]       r_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic                   r_par_err;
    logic [7:0]             r_out_data;
    logic                   r_out_valid;
    logic                   r_rts_n;
    logic                   r_frame_err;
    logic                   r_parity_err;
    logic                   r_overrun;

    logic             w_rx_s;
    logic [DIV_W-1:0] w_div_eff;
    logic             w_half_hit;
    logic             w_bit_hit;
    logic             w_stop_hit;
    logic             w_deliver;
    logic             w_load;
    logic             w_valid_next;

    assign w_rx_s    = r_sync[SYNC_STAGES-1];
    assign w_div_eff = (divisor < DIV_W'(4)) ? DIV_W'(4) : divisor;

    // cnt is 0 on the first clock after a (re)start, so "reaching" N is cnt == N-1.
    assign w_half_hit = (r_cnt == (r_div_q >> 1) - DIV_W'(1));
    assign w_bit_hit  = (r_cnt == r_div_q - DIV_W'(1));

    assign w_stop_hit = enable && (r_state == StStop) && w_bit_hit;
    assign w_deliver  = w_stop_hit && w_rx_s && !r_par_err;

    // A delivery only lands if the register is empty or being drained this cycle.
    assign w_load       = w_deliver && (!r_out_valid || out_ready);
    assign w_valid_next = w_deliver || (r_out_valid && !out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_sync       <= '1;
            r_rx_s_d     <= 1'b1;
            r_div_q      <= '0;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_rts_n      <= 1'b1;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], rx};
            r_rx_s_d     <= w_rx_s;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;

            r_out_valid <= w_valid_next;
            r_rts_n     <= w_valid_next || !enable;
            if (w_load) begin
                r_out_data <= r_shift;
            end
            if (w_deliver && !w_load) begin
                r_overrun <= 1'b1;
            end

            if (!enable) begin
                r_state <= StIdle;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (r_rx_s_d && !w_rx_s) begin
                            r_cnt     <= '0;
                            r_div_q   <= w_div_eff;
                            r_par_err <= 1'b0;
                            r_state   <= StStart;
                        end
                    end
                    StStart: begin
                        if (w_half_hit) begin
                            if (w_rx_s) begin
                                r_state <= StIdle;
                            end else begin
                                r_cnt     <= '0;
                                r_bit_idx <= '0;
                                r_state   <= StData;
                            end
                        end else begin
                            r_cnt <= r_cnt + DIV_W'(1);
                        end
                    end
                    StData: begin
                        if (w_bit_hit) begin
                            r_shift[r_bit_idx] <= w_rx_s;
                            r_cnt              <= '0;
                            if (r_bit_idx == 3'd7) begin
                                r_state <= parity_en ? StParity : StStop;
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end else begin
                            r_cnt <= r_cnt + DIV_W'(1);
                        end
                    end
                    StParity: begin
                        if (w_bit_hit) begin
                            r_par_err <= (^r_shift) ^ w_rx_s ^ parity_odd;
                            r_cnt     <= '0;
                            r_state   <= StStop;
                        end else begin
                            r_cnt <= r_cnt + DIV_W'(1);
                        end
                    end
                    StStop: begin
                        if (w_bit_hit) begin
                            r_state <= StIdle;
                            // A low stop bit dominates: the parity result is not reported.
                            if (!w_rx_s) begin
                                r_frame_err <= 1'b1;
                            end else if (r_par_err) begin
                                r_parity_err <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + DIV_W'(1);
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign rts_n      = r_rts_n;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: a vector table of frames, randomized
// frames against a frame-level outcome model, and hand sequences for the corners.
module tb_uart_rx_deserializer;

    localparam int unsigned DIV_W = 16;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b1;
    logic             enable     = 1'b1;
    logic [DIV_W-1:0] divisor    = DIV_W'(16);
    logic             parity_en  = 1'b0;
    logic             parity_odd = 1'b0;
    logic             rx         = 1'b1;
    logic             out_ready  = 1'b1;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             rts_n;
    logic             frame_err;
    logic             parity_err;
    logic             overrun;

    uart_rx_deserializer #(
        .DIV_W       (DIV_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .divisor    (divisor),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rx         (rx),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rts_n      (rts_n),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Monitor: counts pulses and collects handshaken bytes, sampled on the falling edge.
    int         cyc      = 0;
    int         fe_cnt   = 0;
    int         pe_cnt   = 0;
    int         ov_cnt   = 0;
    int         v_cnt    = 0;
    int         rise_cyc = -1;
    int         ov_cyc   = -1;
    logic       prev_v   = 1'b0;
    logic [7:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_v <= out_valid;
        if (out_valid === 1'b1 && prev_v !== 1'b1) rise_cyc <= cyc;
        if (out_valid === 1'b1) v_cnt <= v_cnt + 1;
        if (out_valid === 1'b1 && out_ready) got_q.push_back(out_data);
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
        if (overrun === 1'b1) begin
            ov_cnt <= ov_cnt + 1;
            ov_cyc <= cyc;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic b, input int n);
        rx = b;
        tick(n);
    endtask

    function automatic int eff_div(input int raw);
        return (raw < 4) ? 4 : raw;
    endfunction

    // Parity bit value that makes the frame correct.
    function automatic logic good_par(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Drive one complete frame; the divisor input is disturbed after the start bit
    // because the receiver must keep using the value captured at the start edge.
    task automatic send_frame(input int raw, input logic [7:0] data, input logic pen,
                              input logic pbit, input logic stop);
        int d;
        d       = eff_div(raw);
        divisor = DIV_W'(raw);
        drive(1'b0, d);
        divisor = DIV_W'($urandom_range(0, 60));
        for (int i = 0; i < 8; i++) drive(data[i], d);
        if (pen) drive(pbit, d);
        drive(stop, d);
        rx = 1'b1;
    endtask

    int b_fe, b_pe, b_ov, b_v;

    task automatic snap();
        b_fe = fe_cnt;
        b_pe = pe_cnt;
        b_ov = ov_cnt;
        b_v  = v_cnt;
        got_q.delete();
    endtask

    task automatic expect_frame(input string tag, input logic del, input logic [7:0] data,
                                input logic fe, input logic pe);
        chk({tag, " bytes"}, got_q.size(), del ? 1 : 0);
        if (del && got_q.size() > 0) chk({tag, " data"}, int'(got_q[0]), int'(data));
        chk({tag, " frame_err"}, fe_cnt - b_fe, int'(fe));
        chk({tag, " parity_err"}, pe_cnt - b_pe, int'(pe));
        chk({tag, " overrun"}, ov_cnt - b_ov, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       podd;
        logic       pbit;
        logic       stop;
        logic       exp_del;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int c0;
        int raw;
        logic [7:0] d;
        logic pen, podd, pbit, stop, del, fe, pe;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        #2 rst_n = 1'b0;
        tick(3);
        chk("reset out_data", int'(out_data), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset rts_n", int'(rts_n), 1);
        chk("reset pulses", int'({frame_err, parity_err, overrun}), 0);
        rst_n = 1'b1;
        tick(3);
        chk("rts_n after reset", int'(rts_n), 0);

        // 0xA5 at divisor 16: rx_s falls 2 clocks after the line, out_valid 153 later
        snap();
        c0 = cyc;
        send_frame(16, 8'hA5, 1'b0, 1'b0, 1'b1);
        tick(32);
        expect_frame("a5", 1'b1, 8'hA5, 1'b0, 1'b0);
        chk("a5 latency", rise_cyc - c0, 155);
        chk("a5 valid cycles", v_cnt - b_v, 1);

        // Vector table
        foreach (vecs[i]) begin
            parity_en  = vecs[i].pen;
            parity_odd = vecs[i].podd;
            snap();
            send_frame(16, vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].stop);
            tick(32);
            expect_frame($sformatf("vec%0d", i), vecs[i].exp_del, vecs[i].data,
                         vecs[i].exp_fe, vecs[i].exp_pe);
        end

        // Randomized frames against the frame-level outcome model
        for (int n = 0; n < 24; n++) begin
            raw  = int'($urandom_range(0, 24));
            d    = 8'($urandom);
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            pbit = good_par(d, podd) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 7) != 0);
            fe   = !stop;
            pe   = stop && pen && (pbit != good_par(d, podd));
            del  = !fe && !pe;
            parity_en  = pen;
            parity_odd = podd;
            snap();
            send_frame(raw, d, pen, pbit, stop);
            tick(2 * eff_div(raw) + 4);
            expect_frame($sformatf("rand%0d div=%0d", n, raw), del, d, fe, pe);
        end
        parity_en = 1'b0;

        // Short low glitch on an idle line is a false start
        divisor = DIV_W'(16);
        snap();
        drive(1'b0, 4);
        drive(1'b1, 64);
        expect_frame("glitch", 1'b0, 8'h00, 1'b0, 1'b0);

        // Bad stop bit followed by a long break: one frame_err, then clean recovery
        snap();
        send_frame(16, 8'h55, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 40 * 16);
        drive(1'b1, 40);
        expect_frame("break", 1'b0, 8'h00, 1'b1, 1'b0);
        snap();
        send_frame(16, 8'h12, 1'b0, 1'b0, 1'b1);
        tick(32);
        expect_frame("after break", 1'b1, 8'h12, 1'b0, 1'b0);

        // Overrun: consumer stalled across two back-to-back frames
        out_ready = 1'b0;
        snap();
        send_frame(16, 8'h11, 1'b0, 1'b0, 1'b1);
        c0 = cyc;
        send_frame(16, 8'h22, 1'b0, 1'b0, 1'b1);
        tick(32);
        chk("ovr out_valid", int'(out_valid), 1);
        chk("ovr out_data", int'(out_data), 'h11);
        chk("ovr rts_n", int'(rts_n), 1);
        chk("ovr count", ov_cnt - b_ov, 1);
        chk("ovr timing", ov_cyc - c0, 155);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("ovr drained byte", (got_q.size() == 1) ? int'(got_q[0]) : -1, 'h11);
        chk("ovr drained valid", int'(out_valid), 0);
        chk("ovr drained rts_n", int'(rts_n), 0);

        // Same pair, but the consumer accepts exactly on the delivery cycle
        snap();
        send_frame(16, 8'h11, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(16, 8'h22, 1'b0, 1'b0, 1'b1);
            begin
                tick(154);
                out_ready = 1'b1;
                tick(1);
                out_ready = 1'b0;
            end
        join
        tick(32);
        chk("swap out_data", int'(out_data), 'h22);
        chk("swap out_valid", int'(out_valid), 1);
        chk("swap overrun", ov_cnt - b_ov, 0);
        chk("swap consumed", (got_q.size() == 1) ? int'(got_q[0]) : -1, 'h11);
        out_ready = 1'b1;
        tick(2);

        // Asynchronous reset mid-frame with a full holding register
        out_ready = 1'b0;
        send_frame(16, 8'h33, 1'b0, 1'b0, 1'b1);
        tick(8);
        drive(1'b0, 16);
        drive(1'b1, 16);
        drive(1'b0, 10);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", int'(out_valid), 0);
        chk("async rst out_data", int'(out_data), 0);
        chk("async rst rts_n", int'(rts_n), 1);
        rx = 1'b1;
        tick(3);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick(4);
        snap();
        send_frame(16, 8'h3C, 1'b0, 1'b0, 1'b1);
        tick(32);
        expect_frame("after rst", 1'b1, 8'h3C, 1'b0, 1'b0);

        // Full-rate divisor, then enable dropped during data bit 3
        snap();
        send_frame(2604, 8'hC3, 1'b0, 1'b0, 1'b1);
        tick(8);
        expect_frame("div2604", 1'b1, 8'hC3, 1'b0, 1'b0);
        divisor = DIV_W'(2604);
        snap();
        drive(1'b0, 2604);
        drive(1'b1, 3 * 2604 + 1302);
        enable = 1'b0;
        tick(2);
        chk("disabled rts_n", int'(rts_n), 1);
        tick(10);
        enable = 1'b1;
        tick(6 * 2604 + 100);
        expect_frame("abort", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("abort rts_n", int'(rts_n), 0);
        snap();
        send_frame(16, 8'h5A, 1'b0, 1'b0, 1'b1);
        tick(32);
        expect_frame("reenable", 1'b1, 8'h5A, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
